// File: rtl/cu_sched_pkg.sv
// cu_sched_pkg: shared types for the layer scheduler.
// FSM states, descriptor bundle and tiling shifts.
package cu_sched_pkg;

  localparam int COL_DEF       = 8;
  localparam int TILE_LEN_DEF  = 16;
  localparam int LOG2_COL      = $clog2(COL_DEF);
  localparam int LOG2_TILE_LEN = $clog2(TILE_LEN_DEF);

  localparam int ID_W  = 4;
  localparam int CHN_W = 4;
  localparam int FMS_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CHN_W-1:0] chi;
    logic [CHN_W-1:0] cho;
    logic             stride;
    logic [FMS_W-1:0] ifm_size;
  } desc_t;

endpackage

// File: rtl/conv_layer_sched_tile_cfg_calc.sv
// tile_cfg_calc: output size and tile split of a layer.
// Purely combinational; the scheduler registers it in CFG.
module tile_cfg_calc #(
  parameter int COL          = 8,
  parameter int TILE_LEN     = 16,
  parameter int FMS_WIDTH    = 8,
  parameter int TC_ROW_WIDTH = 6,
  parameter int TC_COL_WIDTH = 6,
  parameter int PC_ROW_WIDTH = 4,
  parameter int PC_COL_WIDTH = 4
) (
  input  logic                    stride,
  input  logic [FMS_WIDTH-1:0]    ifm_size,
  output logic [TC_ROW_WIDTH-1:0] tc_row_max,
  output logic [TC_COL_WIDTH-1:0] tc_col_max,
  output logic [PC_ROW_WIDTH-1:0] tile_row_offset,
  output logic [PC_COL_WIDTH-1:0] tile_col_offset
);

  localparam int LC = $clog2(COL);
  localparam int LT = $clog2(TILE_LEN);

  logic [FMS_WIDTH-1:0] half;
  logic [FMS_WIDTH-1:0] ofm;
  logic [FMS_WIDTH-1:0] ofm_m1;
  logic [FMS_WIDTH-1:0] row_q;
  logic [FMS_WIDTH-1:0] col_q;
  logic [FMS_WIDTH-1:0] row_r;
  logic [FMS_WIDTH-1:0] col_r;

  // ofm, tile counts and remainders
  always_comb begin
    half   = ((ifm_size - FMS_WIDTH'(1)) >> 1)
             + FMS_WIDTH'(1);
    ofm    = stride ? half : ifm_size;
    ofm_m1 = ofm - FMS_WIDTH'(1);
    row_q  = ofm_m1 >> LC;
    col_q  = ofm_m1 >> LT;
    row_r  = ofm & FMS_WIDTH'(COL - 1);
    col_r  = ofm & FMS_WIDTH'(TILE_LEN - 1);
  end

  assign tc_row_max      = TC_ROW_WIDTH'(row_q);
  assign tc_col_max      = TC_COL_WIDTH'(col_q);
  assign tile_row_offset = PC_ROW_WIDTH'(row_r);
  assign tile_col_offset = PC_COL_WIDTH'(col_r);

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: queues layer descriptors and sequences pea_ctrl.
// Optional LAYER_PERF_CNT_EN adds a per-layer cycle counter.
import cu_sched_pkg::*;

module conv_layer_sched #(
  parameter int COL          = 1 << LOG2_COL,
  parameter int TILE_LEN     = 1 << LOG2_TILE_LEN,
  parameter int CHN_WIDTH    = CHN_W,
  parameter int FMS_WIDTH    = FMS_W,
  parameter int TC_ROW_WIDTH = 6,
  parameter int TC_COL_WIDTH = 6,
  parameter int PC_ROW_WIDTH = 4,
  parameter int PC_COL_WIDTH = 4,
  parameter int DESC_DEPTH   = 2,
  parameter int DRAIN_CYCLES = 6,
  parameter int ID_WIDTH     = ID_W
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    desc_valid,
  output logic                    desc_ready,
  input  logic [ID_WIDTH-1:0]     desc_id,
  input  logic [CHN_WIDTH-1:0]    desc_chi,
  input  logic [CHN_WIDTH-1:0]    desc_cho,
  input  logic                    desc_stride,
  input  logic [FMS_WIDTH-1:0]    desc_ifm_size,
  input  logic                    clear,
  output logic [CHN_WIDTH-1:0]    chi,
  output logic [CHN_WIDTH-1:0]    cho,
  output logic                    stride,
  output logic [FMS_WIDTH-1:0]    ifm_size,
  output logic [PC_ROW_WIDTH-1:0] tile_row_offset,
  output logic [PC_COL_WIDTH-1:0] tile_col_offset,
  output logic [TC_ROW_WIDTH-1:0] tc_row_max,
  output logic [TC_COL_WIDTH-1:0] tc_col_max,
  output logic                    start_conv,
  input  logic                    conv_done,
  output logic                    busy,
  output logic                    layer_done,
  output logic [ID_WIDTH-1:0]     layer_done_id,
`ifdef LAYER_PERF_CNT_EN
  output logic [31:0]             perf_cycles,
`endif
  output logic                    desc_err
);

  localparam int AW = $clog2(DESC_DEPTH);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_t st, nxt;

  desc_t mem [DESC_DEPTH];
  desc_t wdesc;
  desc_t cur;

  logic [AW:0]   wptr, rptr;
  logic          full, empty;
  logic          xfer, bad, push, pop;
  logic          err_q;
  logic [DW-1:0] dcnt;

  logic [TC_ROW_WIDTH-1:0] c_row_max, r_row_max;
  logic [TC_COL_WIDTH-1:0] c_col_max, r_col_max;
  logic [PC_ROW_WIDTH-1:0] c_row_off, r_row_off;
  logic [PC_COL_WIDTH-1:0] c_col_off, r_col_off;

  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty = (wptr == rptr);

  assign desc_ready = !full;
  assign xfer = desc_valid && desc_ready;
  assign bad  = (desc_ifm_size == '0) ||
                (desc_chi == '0) ||
                (desc_cho == '0);
  assign push = xfer && !bad && !clear;

  assign wdesc.id       = ID_W'(desc_id);
  assign wdesc.chi      = CHN_W'(desc_chi);
  assign wdesc.cho      = CHN_W'(desc_cho);
  assign wdesc.stride   = desc_stride;
  assign wdesc.ifm_size = FMS_W'(desc_ifm_size);

  // descriptor storage; pointers qualify the contents
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= wdesc;
  end

  // FIFO pointers; clear empties the queue
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  // rejected descriptor flag, one cycle after transfer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_q <= 1'b0;
    else       err_q <= xfer && bad;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) st <= S_IDLE;
    else       st <= nxt;
  end

  // next state and pop decision
  always_comb begin
    nxt = st;
    pop = 1'b0;
    if (clear) begin
      nxt = S_IDLE;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (!empty) begin
            nxt = S_CFG;
            pop = 1'b1;
          end
        end
        S_CFG:   nxt = S_START;
        S_START: nxt = S_RUN;
        S_RUN:   if (conv_done) nxt = S_DRAIN;
        S_DRAIN: if (dcnt == '0) nxt = S_DONE;
        S_DONE: begin
          if (!empty) begin
            nxt = S_CFG;
            pop = 1'b1;
          end else begin
            nxt = S_IDLE;
          end
        end
        default: nxt = S_IDLE;
      endcase
    end
  end

  // drain countdown after conv_done
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dcnt <= '0;
    end else if (st == S_RUN && conv_done && !clear) begin
      dcnt <= DW'(DRAIN_CYCLES - 1);
    end else if (st == S_DRAIN && dcnt != '0) begin
      dcnt <= dcnt - 1'b1;
    end
  end

  // latch the popped head as the running layer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    cur <= '0;
    else if (pop) cur <= mem[rptr[AW-1:0]];
  end

  tile_cfg_calc #(
    .COL          (COL),
    .TILE_LEN     (TILE_LEN),
    .FMS_WIDTH    (FMS_WIDTH),
    .TC_ROW_WIDTH (TC_ROW_WIDTH),
    .TC_COL_WIDTH (TC_COL_WIDTH),
    .PC_ROW_WIDTH (PC_ROW_WIDTH),
    .PC_COL_WIDTH (PC_COL_WIDTH)
  ) u_calc (
    .stride          (cur.stride),
    .ifm_size        (FMS_WIDTH'(cur.ifm_size)),
    .tc_row_max      (c_row_max),
    .tc_col_max      (c_col_max),
    .tile_row_offset (c_row_off),
    .tile_col_offset (c_col_off)
  );

  // tile config registered once per layer in CFG
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_row_max <= '0;
      r_col_max <= '0;
      r_row_off <= '0;
      r_col_off <= '0;
    end else if (st == S_CFG) begin
      r_row_max <= c_row_max;
      r_col_max <= c_col_max;
      r_row_off <= c_row_off;
      r_col_off <= c_col_off;
    end
  end

`ifdef LAYER_PERF_CNT_EN
  logic [31:0] pcnt, pinc, phold;

  assign pinc = (pcnt == '1) ? pcnt : pcnt + 1'b1;

  // saturating layer cycle counter and its snapshot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcnt  <= '0;
      phold <= '0;
    end else begin
      if (nxt == S_START && st != S_START) begin
        pcnt <= '0;
      end else if (st == S_START || st == S_RUN ||
                   st == S_DRAIN) begin
        pcnt <= pinc;
      end
      if (st == S_DRAIN && nxt == S_DONE) phold <= pinc;
    end
  end

  assign perf_cycles = phold;
`endif

  assign chi      = CHN_WIDTH'(cur.chi);
  assign cho      = CHN_WIDTH'(cur.cho);
  assign stride   = cur.stride;
  assign ifm_size = FMS_WIDTH'(cur.ifm_size);

  assign tc_row_max      = r_row_max;
  assign tc_col_max      = r_col_max;
  assign tile_row_offset = r_row_off;
  assign tile_col_offset = r_col_off;

  assign start_conv    = (st == S_START);
  assign busy          = (st != S_IDLE);
  assign layer_done    = (st == S_DONE);
  assign layer_done_id = layer_done ?
                         ID_WIDTH'(cur.id) : '0;
  assign desc_err      = err_q;

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed checks of the layer scheduler.
// Expected values are hand-computed from the tiling rules.
module tb_conv_layer_sched;

  logic       clk = 1'b0;
  logic       rstn;
  logic       desc_valid;
  logic       desc_ready;
  logic [3:0] desc_id;
  logic [3:0] desc_chi;
  logic [3:0] desc_cho;
  logic       desc_stride;
  logic [7:0] desc_ifm_size;
  logic       clear;
  logic [3:0] chi;
  logic [3:0] cho;
  logic       stride;
  logic [7:0] ifm_size;
  logic [3:0] tile_row_offset;
  logic [3:0] tile_col_offset;
  logic [5:0] tc_row_max;
  logic [5:0] tc_col_max;
  logic       start_conv;
  logic       conv_done;
  logic       busy;
  logic       layer_done;
  logic [3:0] layer_done_id;
  logic       desc_err;
`ifdef LAYER_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  conv_layer_sched dut (
    .clk             (clk),
    .rstn            (rstn),
    .desc_valid      (desc_valid),
    .desc_ready      (desc_ready),
    .desc_id         (desc_id),
    .desc_chi        (desc_chi),
    .desc_cho        (desc_cho),
    .desc_stride     (desc_stride),
    .desc_ifm_size   (desc_ifm_size),
    .clear           (clear),
    .chi             (chi),
    .cho             (cho),
    .stride          (stride),
    .ifm_size        (ifm_size),
    .tile_row_offset (tile_row_offset),
    .tile_col_offset (tile_col_offset),
    .tc_row_max      (tc_row_max),
    .tc_col_max      (tc_col_max),
    .start_conv      (start_conv),
    .conv_done       (conv_done),
    .busy            (busy),
    .layer_done      (layer_done),
    .layer_done_id   (layer_done_id),
`ifdef LAYER_PERF_CNT_EN
    .perf_cycles     (perf_cycles),
`endif
    .desc_err        (desc_err)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] id,
                      input logic [3:0] ci,
                      input logic [3:0] co,
                      input logic       st,
                      input logic [7:0] sz);
    int n;
    n = 0;
    desc_id       = id;
    desc_chi      = ci;
    desc_cho      = co;
    desc_stride   = st;
    desc_ifm_size = sz;
    desc_valid    = 1'b1;
    while (!desc_ready && n < 30) begin
      tick();
      n++;
    end
    check("push_rdy", 32'(desc_ready), 1);
    tick();
    desc_valid = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (!start_conv && n < 30) begin
      tick();
      n++;
    end
  endtask

  // called in the START cycle of a layer
  task automatic run_conv(input logic [3:0] id);
    int n;
    tick();
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    n = 1;
    while (!layer_done && n < 30) begin
      tick();
      n++;
    end
    check("done_lat", 32'(n), 7);
    check("done_id", 32'(layer_done_id), 32'(id));
`ifdef LAYER_PERF_CNT_EN
    check("perf", perf_cycles, 9);
`endif
  endtask

  task automatic tiles(input int rm, input int ro,
                       input int cm, input int co);
    check("tc_row_max", 32'(tc_row_max), rm);
    check("row_off", 32'(tile_row_offset), ro);
    check("tc_col_max", 32'(tc_col_max), cm);
    check("col_off", 32'(tile_col_offset), co);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n;
    int s;
    int d;
    int b;
    rstn          = 1'b0;
    desc_valid    = 1'b0;
    desc_id       = '0;
    desc_chi      = '0;
    desc_cho      = '0;
    desc_stride   = 1'b0;
    desc_ifm_size = '0;
    clear         = 1'b0;
    conv_done     = 1'b0;
    repeat (3) tick();

    check("rst_ready", 32'(desc_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(start_conv), 0);
    check("rst_done", 32'(layer_done), 0);
    check("rst_err", 32'(desc_err), 0);
    check("rst_chi", 32'(chi), 0);
    check("rst_ifm", 32'(ifm_size), 0);
    tiles(0, 0, 0, 0);
    rstn = 1'b1;
    tick();

    // layer 1: 34, stride 1
    push(4'd1, 4'd2, 4'd1, 1'b0, 8'd34);
    check("pop_busy", 32'(busy), 0);
    wait_start(n);
    check("start_lat", 32'(n), 2);
    check("chi", 32'(chi), 2);
    check("cho", 32'(cho), 1);
    check("ifm", 32'(ifm_size), 34);
    check("stride", 32'(stride), 0);
    tiles(4, 2, 2, 2);
    run_conv(4'd1);
    tick();
    check("idle_busy", 32'(busy), 0);

    // layer 2: 33, stride 2
    push(4'd2, 4'd3, 4'd2, 1'b1, 8'd33);
    wait_start(n);
    check("stride2", 32'(stride), 1);
    tiles(2, 1, 1, 1);
    run_conv(4'd2);
    tick();

    // layer 3: 32, stride 1
    push(4'd3, 4'd1, 4'd1, 1'b0, 8'd32);
    wait_start(n);
    tiles(3, 0, 1, 0);
    run_conv(4'd3);
    tick();

    // three back-to-back descriptors
    push(4'd4, 4'd1, 4'd1, 1'b0, 8'd16);
    push(4'd5, 4'd1, 4'd1, 1'b0, 8'd16);
    push(4'd6, 4'd1, 4'd1, 1'b0, 8'd16);
    check("full_rdy", 32'(desc_ready), 0);
    for (int i = 4; i <= 6; i++) begin
      wait_start(n);
      if (i > 4) check("gap", 32'(n), 2);
      run_conv(4'(i));
    end
    tick();
    check("b2b_idle", 32'(busy), 0);

    // rejected descriptor
    push(4'd7, 4'd0, 4'd1, 1'b0, 8'd20);
    check("err_pulse", 32'(desc_err), 1);
    s = 0;
    b = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) check("err_clr", 32'(desc_err), 0);
      if (start_conv) s++;
      if (busy) b++;
    end
    check("err_nostart", 32'(s), 0);
    check("err_nobusy", 32'(b), 0);
    check("err_rdy", 32'(desc_ready), 1);

    // clear during RUN with one queued
    push(4'd8, 4'd5, 4'd1, 1'b0, 8'd20);
    wait_start(n);
    tick();
    push(4'd9, 4'd6, 4'd1, 1'b0, 8'd20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_idle", 32'(busy), 0);
    check("clr_chi", 32'(chi), 5);
    check("clr_rdy", 32'(desc_ready), 1);
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    s = 0;
    d = 0;
    b = 0;
    for (int i = 0; i < 12; i++) begin
      if (start_conv) s++;
      if (layer_done) d++;
      if (busy) b++;
      tick();
    end
    check("clr_nostart", 32'(s), 0);
    check("clr_nodone", 32'(d), 0);
    check("clr_empty", 32'(b), 0);

    // conv_done in IDLE
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    d = 0;
    b = 0;
    for (int i = 0; i < 8; i++) begin
      if (layer_done) d++;
      if (busy) b++;
      tick();
    end
    check("idle_cd_done", 32'(d), 0);
    check("idle_cd_busy", 32'(b), 0);

    // reset during DRAIN
    push(4'd10, 4'd2, 4'd2, 1'b0, 8'd34);
    wait_start(n);
    tick();
    tick();
    conv_done = 1'b1;
    tick();
    conv_done = 1'b0;
    tick();
    check("drain_busy", 32'(busy), 1);
    #2;
    rstn = 1'b0;
    #1;
    check("ar_busy", 32'(busy), 0);
    check("ar_rdy", 32'(desc_ready), 1);
    check("ar_chi", 32'(chi), 0);
    check("ar_ifm", 32'(ifm_size), 0);
    check("ar_done", 32'(layer_done), 0);
    tiles(0, 0, 0, 0);
    tick();
    rstn = 1'b1;
    d = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (layer_done) d++;
    end
    check("ar_nodone", 32'(d), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
